fetch_ctrl: RTL and testbench

Fetch sequencer that drives the `pc` register's `data_in` and runs the instruction-memory request/acknowledge handshake. It sits in the CPU front end between `pc`, instruction memory and decode. It handles boot to a reset vector, PC+4 sequencing, redirects (branch/jump/trap) and discarding of stale fetches. `pc` stays a plain load-every-cycle register; this block decides what it loads.

---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared constants for the fetch sequencer. The state
//                encodings, the sequential PC step and the default reset
//                vector are kept here so the CPU top level and benches agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Fetch sequencer state encodings (2 bits)
    localparam logic [1:0] c_ST_BOOT    = 2'd0;
    localparam logic [1:0] c_ST_FETCH   = 2'd1;
    localparam logic [1:0] c_ST_HOLD    = 2'd2;
    localparam logic [1:0] c_ST_DISCARD = 2'd3;

    // Sequential instruction stride and default boot address
    localparam logic [31:0] c_PC_STEP              = 32'd4;
    localparam logic [31:0] c_RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Force a redirect destination onto a word boundary
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch sequencer for the CPU front end. Chooses the value the
//                pc register loads each cycle (boot vector, PC+4, redirect
//                target or hold), runs the instruction-memory req/ack
//                handshake, presents fetched words to decode and discards
//                fetches made stale by a redirect.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                pc_in / pc_next       - pc register output / next value
//                imem_req/addr/ack/rdata - instruction memory handshake
//                instr_valid/instr/instr_pc/instr_ready - decode interface
//                redirect_valid/target - branch/jump/trap redirect pulse
//                misaligned_err        - pulse for a misaligned redirect
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misaligned_err
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_stale_addr;
    logic        r_misaligned_err;

    // Redirects are only honoured once the sequencer has left BOOT
    logic        w_redirect;
    logic [31:0] w_target;

    assign w_redirect = redirect_valid && (r_state != c_ST_BOOT);
    assign w_target   = align_pc(redirect_target);

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_ST_BOOT;
            r_instr          <= 32'd0;
            r_instr_pc       <= 32'd0;
            r_stale_addr     <= 32'd0;
            r_misaligned_err <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_misaligned_err <= w_redirect && (redirect_target[1:0] != 2'b00);
            if (r_state == c_ST_FETCH) begin
                if (w_redirect) begin
                    // The in-flight request must still be retired; remember
                    // its address so it stays stable until the stale ack.
                    if (!imem_ack) begin
                        r_stale_addr <= pc_in;
                    end
                end else if (imem_ack) begin
                    r_instr    <= imem_rdata;
                    r_instr_pc <= pc_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_BOOT: begin
                w_state_next = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (w_redirect) begin
                    w_state_next = imem_ack ? c_ST_FETCH : c_ST_DISCARD;
                end else if (imem_ack) begin
                    w_state_next = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                // A redirect flushes the held word; a coincident instr_ready
                // simply completes the handshake on the way out.
                if (w_redirect || instr_ready) begin
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_DISCARD: begin
                if (imem_ack) begin
                    w_state_next = c_ST_FETCH;
                end
            end
            default: begin
                w_state_next = c_ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: pc_next and memory request
    // ------------------------------------------------------------------
    always_comb begin
        pc_next     = pc_in;
        imem_req    = (r_state == c_ST_FETCH) || (r_state == c_ST_DISCARD);
        imem_addr   = (r_state == c_ST_DISCARD) ? r_stale_addr : pc_in;
        instr_valid = (r_state == c_ST_HOLD);
        if (reset || (r_state == c_ST_BOOT)) begin
            pc_next = RESET_VECTOR;
        end else if (w_redirect) begin
            pc_next = w_target;
        end else if ((r_state == c_ST_FETCH) && imem_ack) begin
            pc_next = pc_in + c_PC_STEP;
        end
    end

    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign misaligned_err = r_misaligned_err;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. Models the pc register
//                and instruction memory; fetched words that decode should see
//                are queued when acked and popped when instr_valid rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misaligned_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic mon_prev = 1'b0;

    fetch_ctrl #(.RESET_VECTOR(RV)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_q),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misaligned_err  (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pc register beside the sequencer at CPU top level
    always @(posedge clk) pc_q <= pc_next;

    // Scoreboard: every new presentation to decode must match the queue head
    always @(negedge clk) begin
        if (instr_valid && !mon_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL present: unexpected instr %h @ %h, none required", instr, instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({instr, instr_pc} !== {e.word, e.addr}) begin
                    n_fail++;
                    $display("FAIL present: got %h @ %h, required %h @ %h", instr, instr_pc, e.word, e.addr);
                end
            end
        end
        mon_prev <= instr_valid;
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack        = 1'b0;
        imem_rdata      = 32'd0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
    endtask

    // Ack the current FETCH and record the word decode should receive
    task automatic ack_good(input logic [31:0] word, input logic [31:0] addr);
        exp_t e;
        imem_ack   = 1'b1;
        imem_rdata = word;
        e.word     = word;
        e.addr     = addr;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) step();
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr: got %h required 0", instr); end
        n_checks++; if (instr_pc !== 32'd0) begin n_fail++; $display("FAIL rst_instr_pc: got %h required 0", instr_pc); end
        n_checks++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b required 0", misaligned_err); end
        n_checks++; if (pc_next !== RV) begin n_fail++; $display("FAIL rst_pc_next: got %h required %h", pc_next, RV); end
    endtask

    // Leaves the DUT in HOLD at 0x100 with pc = 0x104
    task automatic test_boot();
        reset = 1'b0;
        #1;
        // cycle 0: BOOT
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_c0_req: got %b required 0", imem_req); end
        n_checks++; if (pc_next !== RV) begin n_fail++; $display("FAIL boot_c0_pc_next: got %h required %h", pc_next, RV); end
        step();
        // cycle 1: FETCH at reset vector, zero-wait ack
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, RV}) begin n_fail++; $display("FAIL boot_c1_fetch: got %b/%h required 1/%h", imem_req, imem_addr, RV); end
        ack_good(32'h0000_0013, RV);
        #1;
        n_checks++; if (pc_next !== 32'h104) begin n_fail++; $display("FAIL boot_c1_pc_next: got %h required 104", pc_next); end
        step();
        imem_ack = 1'b0;
        #1;
        // cycle 2: HOLD
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL boot_c2_valid: got %b required 1", instr_valid); end
        n_checks++; if (pc_q !== 32'h104) begin n_fail++; $display("FAIL boot_c2_pc: got %h required 104", pc_q); end
    endtask

    // Restart at the reset vector; ends in the first FETCH cycle
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) step();
        exp_q.delete();
        reset = 1'b0;
        step();
    endtask

    // Ends in HOLD at 0x100 holding 0x00500093, pc = 0x104
    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({imem_req, imem_addr} !== {1'b1, RV}) begin n_fail++; $display("FAIL wait_addr%0d: got %b/%h required 1/%h", i, imem_req, imem_addr, RV); end
            step();
        end
        ack_good(32'h0050_0093, RV);
        #1;
        n_checks++; if (imem_addr !== RV) begin n_fail++; $display("FAIL wait_ack_addr: got %h required %h", imem_addr, RV); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_early_valid: got %b required 0", instr_valid); end
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if ({instr_valid, instr} !== {1'b1, 32'h0050_0093}) begin n_fail++; $display("FAIL wait_instr: got %b/%h required 1/00500093", instr_valid, instr); end
    endtask

    // Ends in FETCH at 0x104
    task automatic test_backpressure();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({instr_valid, imem_req, instr, pc_q} !== {1'b1, 1'b0, 32'h0050_0093, 32'h104}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b req=%b instr=%h pc=%h required 1/0/00500093/104", i, instr_valid, imem_req, instr, pc_q);
            end
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        #1;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h104}) begin n_fail++; $display("FAIL bp_next_fetch: got %b/%h required 1/104", imem_req, imem_addr); end
    endtask

    // Starts in FETCH at 0x104; ends in HOLD at 0x200
    task automatic test_redirect_outstanding();
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        n_checks++; if (pc_next !== 32'h200) begin n_fail++; $display("FAIL rd_pc_next: got %h required 200", pc_next); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if ({imem_req, imem_addr, pc_q} !== {1'b1, 32'h104, 32'h200}) begin n_fail++; $display("FAIL rd_discard: got req=%b addr=%h pc=%h required 1/104/200", imem_req, imem_addr, pc_q); end
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL rd_stale_addr: got %h required 104", imem_addr); end
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin n_fail++; $display("FAIL rd_target_fetch: got v=%b req=%b addr=%h required 0/1/200", instr_valid, imem_req, imem_addr); end
        ack_good(32'h0010_0113, 32'h200);
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL rd_instr_pc: got %h required 200", instr_pc); end
    endtask

    // Starts in HOLD; ends in FETCH at 0x204
    task automatic test_misaligned();
        redirect_valid  = 1'b1;
        redirect_target = 32'h206;
        #1;
        n_checks++; if ({pc_next, misaligned_err} !== {32'h204, 1'b0}) begin n_fail++; $display("FAIL mis_pc_next: got %h/%b required 204/0", pc_next, misaligned_err); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if ({instr_valid, misaligned_err, imem_addr} !== {1'b0, 1'b1, 32'h204}) begin n_fail++; $display("FAIL mis_flush: got v=%b err=%b addr=%h required 0/1/204", instr_valid, misaligned_err, imem_addr); end
        step();
        #1;
        n_checks++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_width: got %b required 0", misaligned_err); end
    endtask

    // Starts in FETCH at 0x204 (pc already 0x204); ends in FETCH at 0x210
    task automatic test_back_to_back();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h204 + 32'(i * 4);
            #1;
            n_checks++; if ({imem_req, imem_addr} !== {1'b1, a}) begin n_fail++; $display("FAIL b2b_addr%0d: got %b/%h required 1/%h", i, imem_req, imem_addr, a); end
            ack_good(32'hA000_0000 + 32'(i), a);
            step();
            imem_ack = 1'b0;
            step();
        end
        instr_ready = 1'b0;
    endtask

    // Starts in FETCH at 0x210; ends in HOLD at 0xFFFFFFFC with pc = 0
    task automatic test_redirect_edges();
        // redirect and ack in the same FETCH cycle: word dropped
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        imem_ack        = 1'b1;
        imem_rdata      = 32'hBAD0_BAD0;
        step();
        clear_inputs();
        #1;
        n_checks++; if ({instr_valid, imem_addr, instr} !== {1'b0, 32'h300, 32'hA000_0002}) begin n_fail++; $display("FAIL rdack_drop: got v=%b addr=%h instr=%h required 0/300/a0000002", instr_valid, imem_addr, instr); end
        // redirect to the top word, then fetch it: pc wraps to zero
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h required fffffffc", imem_addr); end
        ack_good(32'h1234_5678, 32'hFFFF_FFFC);
        #1;
        n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_next: got %h required 0", pc_next); end
        step();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_before: got %b required 1", imem_req); end
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFACE_FACE;
        step();
        #1;
        n_checks++;
        if ({imem_req, instr_valid, instr, instr_pc, misaligned_err, pc_next} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, RV}) begin
            n_fail++;
            $display("FAIL mid_reset_vals: got req=%b v=%b instr=%h ipc=%h err=%b pcn=%h", imem_req, instr_valid, instr, instr_pc, misaligned_err, pc_next);
        end
        clear_inputs();
        reset = 1'b0;
        step();
        #1;
        n_checks++; if ({imem_req, imem_addr, instr} !== {1'b1, RV, 32'd0}) begin n_fail++; $display("FAIL mid_restart: got req=%b addr=%h instr=%h required 1/%h/0", imem_req, imem_addr, instr, RV); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_wait_states();
        test_backpressure();
        test_redirect_outstanding();
        test_misaligned();
        test_back_to_back();
        test_redirect_edges();
        test_reset_midfetch();
        repeat (2) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d words never presented, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
